apb_xfer_mon: RTL and testbench



---
 rtl/apb_xfer_mon.sv | 147 ++++++++++++++
 tb/tb_apb_xfer_mon.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/apb_xfer_mon.sv
`default_nettype none
// ============================================================================
// Module      : apb_xfer_mon
// Description : Passive APB4 monitor. Reports completed reads/writes, decodes
//               status-register reads into a read-to-clear strobe and counts
//               protocol violations with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_xfer_mon #(
    parameter logic [31:0] BASE_ADDR   = 32'hC0F16000,
    parameter logic [31:0] STAT_OFFSET = 32'h00000004,
    parameter int          ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [31:0]          paddr,
    input  logic                 pready,
    input  logic                 pslverr,
    output logic                 mstr_rd_sync,
    output logic                 mstr_wr_sync,
    output logic                 stat_read,
    output logic                 prot_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);

    localparam logic [31:0] c_stat_addr  = BASE_ADDR + STAT_OFFSET;

    localparam logic [1:0]  c_st_idle    = 2'd0;
    localparam logic [1:0]  c_st_setup   = 2'd1;
    localparam logic [1:0]  c_st_access  = 2'd2;

    logic [1:0]           r_state;
    logic [31:0]          r_paddr_cap;
    logic                 r_pwrite_cap;
    logic                 r_rd_sync;
    logic                 r_wr_sync;
    logic                 r_stat_read;
    logic                 r_prot_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_busy;

    logic [1:0]           w_state_nxt;
    logic                 w_capture;
    logic                 w_complete;
    logic                 w_viol;
    logic                 w_setup;
    logic                 w_access;
    logic                 w_stable;

    // Slave error does not change how a completion is reported.
    logic                 w_unused_pslverr;
    assign w_unused_pslverr = pslverr;

    assign w_setup  = psel & ~penable;
    assign w_access = psel &  penable;
    assign w_stable = (paddr == r_paddr_cap) && (pwrite == r_pwrite_cap);

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_complete  = 1'b0;
        w_viol      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_setup) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_st_setup;
                end else if (w_access) begin
                    w_viol      = 1'b1;
                end
            end
            c_st_setup: begin
                if (w_access && w_stable) begin
                    if (pready) begin
                        w_complete  = 1'b1;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_state_nxt = c_st_access;
                    end
                end else if (w_setup) begin
                    // Repeated SETUP is illegal but starts a fresh transfer.
                    w_viol      = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nxt = c_st_setup;
                end else begin
                    w_viol      = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_access: begin
                if (w_access && w_stable) begin
                    if (pready) begin
                        w_complete  = 1'b1;
                        w_state_nxt = c_st_idle;
                    end
                end else begin
                    w_viol      = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_paddr_cap  <= 32'd0;
            r_pwrite_cap <= 1'b0;
            r_rd_sync    <= 1'b0;
            r_wr_sync    <= 1'b0;
            r_stat_read  <= 1'b0;
            r_prot_err   <= 1'b0;
            r_err_cnt    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            if (w_capture) begin
                r_paddr_cap  <= paddr;
                r_pwrite_cap <= pwrite;
            end
            r_rd_sync    <= w_complete & ~r_pwrite_cap;
            r_wr_sync    <= w_complete &  r_pwrite_cap;
            r_stat_read  <= w_complete & ~r_pwrite_cap & (r_paddr_cap == c_stat_addr);
            r_prot_err   <= w_viol;
            if (w_viol && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
            r_busy       <= (w_state_nxt != c_st_idle);
        end
    end

    assign mstr_rd_sync = r_rd_sync;
    assign mstr_wr_sync = r_wr_sync;
    assign stat_read    = r_stat_read;
    assign prot_err     = r_prot_err;
    assign err_cnt      = r_err_cnt;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_apb_xfer_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_xfer_mon
// Description : Directed self-checking bench for apb_xfer_mon (default and
//               2-bit error counter instances on a shared bus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_xfer_mon;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic        pready;
    logic        pslverr;

    logic        rd_sync, wr_sync, stat_rd, perr, bsy;
    logic [7:0]  ecnt;
    logic        s_rd_sync, s_wr_sync, s_stat_rd, s_perr, s_bsy;
    logic [1:0]  s_ecnt;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    apb_xfer_mon u_dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pready(pready), .pslverr(pslverr),
        .mstr_rd_sync(rd_sync), .mstr_wr_sync(wr_sync), .stat_read(stat_rd),
        .prot_err(perr), .err_cnt(ecnt), .busy(bsy)
    );

    apb_xfer_mon #(.ERR_CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pready(pready), .pslverr(pslverr),
        .mstr_rd_sync(s_rd_sync), .mstr_wr_sync(s_wr_sync), .stat_read(s_stat_rd),
        .prot_err(s_perr), .err_cnt(s_ecnt), .busy(s_bsy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one bus cycle, then sample registered outputs just after the edge.
    task automatic cyc(input logic sel, input logic en, input logic wr,
                       input logic [31:0] addr, input logic rdy);
        psel    = sel;
        penable = en;
        pwrite  = wr;
        paddr   = addr;
        pready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pready = 1'b0; pslverr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bsy), 0);
        chk("rst_rd",   32'(rd_sync), 0);
        chk("rst_wr",   32'(wr_sync), 0);
        chk("rst_perr", 32'(perr), 0);
        chk("rst_ecnt", 32'(ecnt), 0);
        rst = 1'b0;
        idle();

        // Zero-wait write to a non-status address
        cyc(1'b1, 1'b0, 1'b1, 32'hC0F16010, 1'b0);
        chk("t1_busy_setup", 32'(bsy), 1);
        chk("t1_wr_early",   32'(wr_sync), 0);
        cyc(1'b1, 1'b1, 1'b1, 32'hC0F16010, 1'b1);
        chk("t1_wr",   32'(wr_sync), 1);
        chk("t1_rd",   32'(rd_sync), 0);
        chk("t1_stat", 32'(stat_rd), 0);
        chk("t1_busy", 32'(bsy), 0);
        idle();
        chk("t1_wr_off", 32'(wr_sync), 0);
        chk("t1_ecnt",   32'(ecnt), 0);

        // Status register read with 3 wait states; pslverr still a completion
        cyc(1'b1, 1'b0, 1'b0, 32'hC0F16004, 1'b0);
        chk("t2_busy1", 32'(bsy), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'hC0F16004, 1'b0);
            chk("t2_busy_wait", 32'(bsy), 1);
            chk("t2_rd_wait",   32'(rd_sync), 0);
        end
        pslverr = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 32'hC0F16004, 1'b1);
        pslverr = 1'b0;
        chk("t2_rd",   32'(rd_sync), 1);
        chk("t2_stat", 32'(stat_rd), 1);
        chk("t2_busy", 32'(bsy), 0);
        idle();
        chk("t2_rd_off",   32'(rd_sync), 0);
        chk("t2_stat_off", 32'(stat_rd), 0);

        // Back-to-back read 0x0 then write 0x8
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t3_rd",   32'(rd_sync), 1);
        chk("t3_stat", 32'(stat_rd), 0);
        cyc(1'b1, 1'b0, 1'b1, 32'h8, 1'b0);
        chk("t3_rd_off",   32'(rd_sync), 0);
        chk("t3_wr_early", 32'(wr_sync), 0);
        chk("t3_perr0",    32'(perr), 0);
        cyc(1'b1, 1'b1, 1'b1, 32'h8, 1'b1);
        chk("t3_wr",    32'(wr_sync), 1);
        chk("t3_rd2",   32'(rd_sync), 0);
        chk("t3_perr1", 32'(perr), 0);
        idle();
        chk("t3_ecnt", 32'(ecnt), 0);

        // Violations: ACCESS without SETUP, then address change in ACCESS
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t4_perr_a", 32'(perr), 1);
        chk("t4_rd_a",   32'(rd_sync), 0);
        chk("t4_ecnt_a", 32'(ecnt), 1);
        idle();
        chk("t4_perr_off", 32'(perr), 0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_busy_acc", 32'(bsy), 1);
        cyc(1'b1, 1'b1, 1'b0, 32'h4, 1'b1);
        chk("t4_perr_b", 32'(perr), 1);
        chk("t4_rd_b",   32'(rd_sync), 0);
        chk("t4_busy_b", 32'(bsy), 0);
        idle();
        chk("t4_rd_off", 32'(rd_sync), 0);
        chk("t4_ecnt",   32'(ecnt), 2);
        chk("t4_secnt",  32'(s_ecnt), 2);

        // Five more violations: 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 32'h20, 1'b1);
            chk("t5_perr", 32'(s_perr), 1);
        end
        idle();
        chk("t5_secnt", 32'(s_ecnt), 3);
        chk("t5_ecnt",  32'(ecnt), 7);

        // Reset mid-ACCESS drops the transfer
        cyc(1'b1, 1'b0, 1'b0, 32'h10, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h10, 1'b0);
        chk("t6_busy_pre", 32'(bsy), 1);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 32'h10, 1'b1);
        rst = 1'b0;
        chk("t6_busy", 32'(bsy), 0);
        chk("t6_rd",   32'(rd_sync), 0);
        chk("t6_ecnt", 32'(ecnt), 0);
        chk("t6_secnt", 32'(s_ecnt), 0);
        idle();
        chk("t6_rd_off", 32'(rd_sync), 0);
        chk("t6_perr",   32'(perr), 0);
        cyc(1'b1, 1'b0, 1'b0, 32'hC0F16004, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'hC0F16004, 1'b1);
        chk("t6_rd_clean",   32'(rd_sync), 1);
        chk("t6_stat_clean", 32'(stat_rd), 1);
        chk("t6_wr_clean",   32'(wr_sync), 0);
        idle();
        chk("t6_ecnt_end", 32'(ecnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
